// File: rtl/bus_pkg.sv
// Shared definitions for the bit-serial master/arbiter bus: response codes,
// bus field widths and the slave's state encoding.
package bus_pkg;

   localparam int BUS_ADDR_W = 12;
   localparam int BUS_DATA_W = 32;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_t;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      WAIT,
      RESP,
      RDATA
   } slave_state_t;

endpackage

// File: rtl/slave_ram.sv
// Single-port word RAM with a registered read port; the read register
// unloads LSB first so it can drive the serial read line directly.
module slave_ram
   import bus_pkg::*;
#(
   parameter int MEM_DEPTH = 1024,
   parameter int AW        = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         addr,
   input  logic [BUS_DATA_W-1:0] wdata,
   input  logic                  rd_load,
   input  logic                  rd_shift,
   output logic                  rd_bit
);

   logic [BUS_DATA_W-1:0] mem [MEM_DEPTH];
   logic [BUS_DATA_W-1:0] rd_sr;

   // Zero-fill while shifting and clear when idle, so the line reads 0 outside a data phase.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (rd_load)
         rd_sr <= mem[addr];
      else if (rd_shift)
         rd_sr <= {1'b0, rd_sr[BUS_DATA_W-1:1]};
      else
         rd_sr <= '0;
   end

   assign rd_bit = rd_sr[0];

endmodule

// File: rtl/slave.sv
// Bit-serial bus slave: deserialises address/write data, completes against a
// local RAM after WAIT_CYCLES wait states and answers with HREADY/HRESP/HRDATA.
module slave
   import bus_pkg::*;
#(
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       HSEL,
   input  logic       HWRITE,
   input  logic       HADDR,
   input  logic       HWDATA,
   output logic       HREADY,
   output logic [1:0] HRESP,
   output logic       HRDATA
);

   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [WW-1:0]       WAIT_LAST = WW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [BUS_ADDR_W:0] DEPTH_LIM = MEM_DEPTH[BUS_ADDR_W:0];

   slave_state_t state, nxt;
   logic [5:0]            cnt;
   logic [WW-1:0]         wcnt;
   logic                  armed;
   logic                  hwrite_q;
   logic [BUS_ADDR_W-1:0] addr_sr;
   logic [BUS_DATA_W-1:0] wdata_sr;

   logic                  start;
   logic [BUS_ADDR_W-1:0] addr_next;
   logic [BUS_ADDR_W-1:0] addr_chk;
   logic                  addr_ok;
   logic                  ram_we;
   logic                  rd_load;
   logic                  rd_shift;

   assign start     = (state == IDLE) && HSEL && armed;
   assign addr_next = {HADDR, addr_sr[BUS_ADDR_W-1:1]};
   // On the last address cycle the final bit is still on the wire, so decode it live.
   assign addr_chk  = (state == ADDR) ? addr_next : addr_sr;
   assign addr_ok   = ({1'b0, addr_chk} < DEPTH_LIM);

   always_comb begin
      nxt = state;
      if (state != IDLE && !HSEL) begin
         nxt = IDLE;
      end else begin
         case (state)
            IDLE:  if (start) nxt = ADDR;
            ADDR:
               if (cnt == 6'd11) begin
                  if (hwrite_q)             nxt = WDATA;
                  else if (WAIT_CYCLES > 0) nxt = WAIT;
                  else                      nxt = addr_ok ? RDATA : RESP;
               end
            WDATA: if (cnt == 6'd31) nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT:
               if (wcnt == WAIT_LAST) nxt = (hwrite_q || !addr_ok) ? RESP : RDATA;
            RESP:  nxt = IDLE;
            RDATA: if (cnt == 6'd31) nxt = IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         cnt    <= '0;
         wcnt   <= '0;
         armed  <= 1'b0;
         HREADY <= 1'b0;
         HRESP  <= HRESP_OKAY;
      end else begin
         state <= nxt;
         cnt   <= (nxt != state) ? ((nxt == ADDR) ? 6'd1 : 6'd0) : cnt + 6'd1;
         wcnt  <= (nxt != state) ? '0 : wcnt + WW'(1);
         if ((state == RESP || state == RDATA) && nxt != state)
            armed <= 1'b0;
         else if (!HSEL)
            armed <= 1'b1;
         HREADY <= (nxt == RESP) || (nxt == RDATA);
         HRESP  <= ((nxt == RESP) && !addr_ok) ? HRESP_ERROR : HRESP_OKAY;
      end
   end

   always_ff @(posedge CLK) begin
      if (start) hwrite_q <= HWRITE;
      if (start || state == ADDR) addr_sr <= addr_next;
      if (state == WDATA) wdata_sr <= {HWDATA, wdata_sr[BUS_DATA_W-1:1]};
   end

   assign ram_we   = (state == RESP) && hwrite_q && addr_ok && HSEL && !RST;
   assign rd_load  = !RST && (nxt == RDATA) && (state != RDATA);
   assign rd_shift = !RST && (nxt == RDATA) && (state == RDATA);

   slave_ram #(
      .MEM_DEPTH (MEM_DEPTH),
      .AW        (AW)
   ) u_ram (
      .clk      (CLK),
      .we       (ram_we),
      .addr     (addr_chk[AW-1:0]),
      .wdata    (wdata_sr),
      .rd_load  (rd_load),
      .rd_shift (rd_shift),
      .rd_bit   (HRDATA)
   );

endmodule

// File: tb/tb_slave.sv
// Bench for the serial bus slave: one instance with two wait states, one with none.
module tb_slave;

   localparam int WIN = 56;

   logic       clk = 1'b0;
   logic [1:0] rst = 2'b11;
   logic [1:0] hsel = 2'b00;
   logic [1:0] hwrite = 2'b00;
   logic [1:0] haddr = 2'b00;
   logic [1:0] hwdata = 2'b00;
   wire  [1:0] hready;
   wire  [1:0] hrdata;
   wire  [3:0] hresp;

   int checks = 0;
   int errors = 0;

   logic       s_rdy;
   logic [1:0] s_resp;
   logic       s_rd;

   logic [31:0] mdl [2][1024];

   always #5 clk = ~clk;

   slave #(.MEM_DEPTH(1024), .WAIT_CYCLES(2)) dut_w2 (
      .CLK(clk), .RST(rst[0]), .HSEL(hsel[0]), .HWRITE(hwrite[0]), .HADDR(haddr[0]),
      .HWDATA(hwdata[0]), .HREADY(hready[0]), .HRESP(hresp[1:0]), .HRDATA(hrdata[0]));

   slave #(.MEM_DEPTH(1024), .WAIT_CYCLES(0)) dut_w0 (
      .CLK(clk), .RST(rst[1]), .HSEL(hsel[1]), .HWRITE(hwrite[1]), .HADDR(haddr[1]),
      .HWDATA(hwdata[1]), .HREADY(hready[1]), .HRESP(hresp[3:2]), .HRDATA(hrdata[1]));

   task automatic check(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // One clock: drive inputs just after the edge, sample outputs mid-cycle.
   task automatic step(int d, bit sel, bit wr, bit ad, bit wd, bit r);
      @(posedge clk);
      #1;
      hsel[d] = sel; hwrite[d] = wr; haddr[d] = ad; hwdata[d] = wd; rst[d] = r;
      #4;
      s_rdy  = hready[d];
      s_resp = (d == 0) ? hresp[1:0] : hresp[3:2];
      s_rd   = hrdata[d];
   endtask

   // HSEL low for one cycle, then a transfer window with HSEL held high
   // (unless aborted); collects the response phase.
   task automatic xfer(int d, bit wr, logic [11:0] addr, logic [31:0] data, int abort_at,
                       int rst_at, output int first, output int count,
                       output logic [1:0] resp, output logic [31:0] word, output int bad);
      int  last;
      bit  sel;
      first = -1; count = 0; resp = 2'b00; word = '0; bad = 0; last = -1;
      step(d, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      for (int c = 0; c < WIN; c++) begin
         sel = (abort_at < 0) || (c < abort_at);
         step(d, sel, (c == 0) ? wr : 1'($urandom),
              (c < 12) ? addr[c] : 1'($urandom),
              (c >= 12 && c < 44) ? data[c-12] : 1'($urandom),
              c == rst_at);
         if (s_rdy === 1'b1) begin
            if (first < 0) begin
               first = c;
               resp  = s_resp;
            end else if (s_resp !== resp) bad++;
            if (last >= 0 && last != c - 1) bad++;
            if (count < 32) word[count] = s_rd;
            last = c;
            count++;
         end else if (s_rdy !== 1'b0 || s_resp !== 2'b00 || s_rd !== 1'b0) begin
            bad++;
         end
      end
   endtask

   // Expected behaviour straight from the transfer rules, tracking RAM contents.
   task automatic model_xfer(int d, bit wr, logic [11:0] addr, logic [31:0] data, int ab,
                             string tag);
      int          w, e_first, e_count, first, count, bad;
      bit          ok;
      logic [1:0]  e_resp, resp;
      logic [31:0] e_data, word;
      w  = (d == 0) ? 2 : 0;
      ok = (addr < 12'd1024);
      e_data = '0;
      if (ab >= 0) begin
         e_first = -1; e_count = 0; e_resp = 2'b00;
      end else if (wr) begin
         e_first = 44 + w; e_count = 1; e_resp = ok ? 2'b00 : 2'b01;
      end else if (ok) begin
         e_first = 12 + w; e_count = 32; e_resp = 2'b00; e_data = mdl[d][addr[9:0]];
      end else begin
         e_first = 12 + w; e_count = 1; e_resp = 2'b01;
      end
      xfer(d, wr, addr, data, ab, -1, first, count, resp, word, bad);
      check($sformatf("%s.first", tag), first, e_first);
      check($sformatf("%s.count", tag), count, e_count);
      if (e_count > 0) check($sformatf("%s.resp", tag), {30'd0, resp}, {30'd0, e_resp});
      if (!wr && e_count > 0) check($sformatf("%s.data", tag), word, e_data);
      check($sformatf("%s.clean", tag), bad, 0);
      if (wr && ok && ab < 0) mdl[d][addr[9:0]] = data;
   endtask

   typedef struct {
      int          d;
      bit          wr;
      logic [11:0] addr;
      logic [31:0] data;
      int          abort_at;
      int          rst_at;
      int          e_first;
      int          e_count;
      logic [1:0]  e_resp;
      bit          chk;
      logic [31:0] e_data;
   } vec_t;

   vec_t tbl [21];
   logic [11:0] pool [12];

   initial begin
      int          first, count, bad;
      logic [1:0]  resp;
      logic [31:0] word;

      tbl = '{
         '{0, 1'b1, 12'h000, 32'hA5A50F0F, -1, -1, 46,  1, 2'b00, 1'b0, 32'h0},
         '{0, 1'b1, 12'h005, 32'hDEADBEEF, -1, -1, 46,  1, 2'b00, 1'b0, 32'h0},
         '{0, 1'b0, 12'h005, 32'h0,        -1, -1, 14, 32, 2'b00, 1'b1, 32'hDEADBEEF},
         '{0, 1'b1, 12'h800, 32'h5555AAAA, -1, -1, 46,  1, 2'b01, 1'b0, 32'h0},
         '{0, 1'b0, 12'h800, 32'h0,        -1, -1, 14,  1, 2'b01, 1'b1, 32'h0},
         '{0, 1'b0, 12'h000, 32'h0,        -1, -1, 14, 32, 2'b00, 1'b1, 32'hA5A50F0F},
         '{0, 1'b1, 12'h006, 32'h12345678, -1, -1, 46,  1, 2'b00, 1'b0, 32'h0},
         '{0, 1'b1, 12'h006, 32'hFFFFFFFF, 20, -1, -1,  0, 2'b00, 1'b0, 32'h0},
         '{0, 1'b0, 12'h006, 32'h0,        -1, -1, 14, 32, 2'b00, 1'b1, 32'h12345678},
         '{0, 1'b1, 12'h3FF, 32'h80000001, -1, -1, 46,  1, 2'b00, 1'b0, 32'h0},
         '{0, 1'b0, 12'h3FF, 32'h0,        -1, -1, 14, 32, 2'b00, 1'b1, 32'h80000001},
         '{0, 1'b1, 12'h400, 32'hFFFFFFFF, -1, -1, 46,  1, 2'b01, 1'b0, 32'h0},
         '{0, 1'b0, 12'h400, 32'h0,        -1, -1, 14,  1, 2'b01, 1'b1, 32'h0},
         '{0, 1'b0, 12'h005, 32'h0,        -1, 25, 14, 12, 2'b00, 1'b0, 32'h0},
         '{0, 1'b0, 12'h005, 32'h0,        -1, -1, 14, 32, 2'b00, 1'b1, 32'hDEADBEEF},
         '{1, 1'b1, 12'h010, 32'hCAFEF00D, -1, -1, 44,  1, 2'b00, 1'b0, 32'h0},
         '{1, 1'b0, 12'h010, 32'h0,        -1, -1, 12, 32, 2'b00, 1'b1, 32'hCAFEF00D},
         '{1, 1'b0, 12'hFFF, 32'h0,        -1, -1, 12,  1, 2'b01, 1'b1, 32'h0},
         '{1, 1'b1, 12'hC00, 32'h00000001, -1, -1, 44,  1, 2'b01, 1'b0, 32'h0},
         '{1, 1'b0, 12'h010, 32'h0,         5, -1, -1,  0, 2'b00, 1'b0, 32'h0},
         '{1, 1'b0, 12'h010, 32'h0,        -1, -1, 12, 32, 2'b00, 1'b1, 32'hCAFEF00D}
      };
      pool = '{12'h000, 12'h001, 12'h005, 12'h006, 12'h155, 12'h2AA, 12'h3FE, 12'h3FF,
               12'h400, 12'h800, 12'hC05, 12'hFFF};

      // Reset both instances, then confirm quiet outputs.
      for (int i = 0; i < 3; i++) begin
         step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      rst = 2'b00;
      for (int d = 0; d < 2; d++) begin
         step(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         check($sformatf("reset%0d.hready", d), {31'd0, s_rdy}, 32'd0);
         check($sformatf("reset%0d.hresp", d), {30'd0, s_resp}, 32'd0);
         check($sformatf("reset%0d.hrdata", d), {31'd0, s_rd}, 32'd0);
      end

      foreach (tbl[i]) begin
         xfer(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].abort_at, tbl[i].rst_at,
              first, count, resp, word, bad);
         check($sformatf("v%0d.first", i), first, tbl[i].e_first);
         check($sformatf("v%0d.count", i), count, tbl[i].e_count);
         if (tbl[i].e_count > 0)
            check($sformatf("v%0d.resp", i), {30'd0, resp}, {30'd0, tbl[i].e_resp});
         if (tbl[i].chk) check($sformatf("v%0d.data", i), word, tbl[i].e_data);
         check($sformatf("v%0d.clean", i), bad, 0);
      end

      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 8; k++) begin
            model_xfer(d, 1'b1, pool[k], $urandom, -1, $sformatf("init%0d_%0d", d, k));
         end
      end

      for (int n = 0; n < 30; n++) begin
         int          d, f, ab;
         bit          wr;
         logic [11:0] addr;
         d    = int'($urandom_range(1, 0));
         wr   = 1'($urandom);
         addr = pool[$urandom_range(11, 0)];
         f    = wr ? (d == 0 ? 46 : 44) : (d == 0 ? 14 : 12);
         ab   = ($urandom_range(4, 0) == 0) ? int'($urandom_range(f - 1, 0)) : -1;
         model_xfer(d, wr, addr, $urandom, ab, $sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
